// File: rtl/cpu_mem_responder_pkg.sv
`default_nettype none
//==============================================================================
// cpu_mem_responder_pkg : shared FSM type and sizing constants.
// Revision 1.0
//==============================================================================
package cpu_mem_responder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

endpackage
`default_nettype wire

// File: rtl/cpu_mem_responder_bw_sram.sv
`default_nettype none
//==============================================================================
// bw_sram : synchronous single-port read-first RAM with byte write enables.
// Revision 1.0
//==============================================================================
module bw_sram #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_re,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [3:0]           i_we,
    input  logic [31:0]          i_din,
    output logic [31:0]          o_dout
);

    localparam int c_DEPTH = 1 << ADDR_BITS;

    logic [3:0][7:0] r_mem [c_DEPTH];
    logic [31:0]     r_dout;

    // Storage is deliberately not reset; contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][b] <= i_din[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (i_en && i_re) begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
//==============================================================================
// cpu_mem_responder : fixed-latency data-memory responder for a stalling CPU.
// Revision 1.0
//==============================================================================
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        stall,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    generate
        if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_bad_latency
            $error("cpu_mem_responder: LATENCY=%0d outside 0..%0d", LATENCY, LATENCY_MAX);
        end
        if (ADDR_BITS < 1 || ADDR_BITS > 31) begin : g_bad_addr_bits
            $error("cpu_mem_responder: ADDR_BITS=%0d outside 1..31", ADDR_BITS);
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [3:0]            r_we;
    logic [31:0]           r_din;
    logic                  r_re;
    logic [31:0]           r_rd_count;
    logic [31:0]           r_wr_count;

    logic                  w_req;
    logic                  w_stall;
    logic                  w_acc_en;
    logic                  w_acc_re;
    logic [3:0]            w_acc_we;
    logic [31:0]           w_acc_din;
    logic [ADDR_BITS-1:0]  w_acc_addr;
    logic                  w_addr_unused;

    assign w_req         = re || (we != 4'b0000);
    assign w_addr_unused = ^addr[31:ADDR_BITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // With LATENCY<=1 the access lands on the request edge itself, so live
    // inputs are used and WAIT is never entered; the single stall cycle (if
    // any) is the request cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_acc_en    = 1'b0;
        w_acc_re    = re;
        w_acc_we    = we;
        w_acc_din   = din;
        w_acc_addr  = addr[ADDR_BITS-1:0];
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_stall = (LATENCY > 0);
                    if (LATENCY > 1) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_acc_en = 1'b1;
                    end
                end
            end
            WAIT: begin
                w_stall    = 1'b1;
                w_acc_re   = r_re;
                w_acc_we   = r_we;
                w_acc_din  = r_din;
                w_acc_addr = r_addr;
                if (r_cnt == CNT_W'(1)) begin
                    w_acc_en    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (reset) begin
            w_stall  = 1'b0;
            w_acc_en = 1'b0;
        end
    end

    // Counter reaches zero on the edge that performs the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_we   <= '0;
            r_din  <= '0;
            r_re   <= 1'b0;
        end else if (r_state == IDLE && w_state_nxt == WAIT) begin
            r_cnt  <= CNT_W'(LATENCY - 1);
            r_addr <= addr[ADDR_BITS-1:0];
            r_we   <= we;
            r_din  <= din;
            r_re   <= re;
        end else if (r_state == WAIT) begin
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_acc_en) begin
            if (w_acc_re) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_acc_we != 4'b0000) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    bw_sram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_sram (
        .clk    (clk),
        .rst    (reset),
        .i_en   (w_acc_en),
        .i_re   (w_acc_re),
        .i_addr (w_acc_addr),
        .i_we   (w_acc_we),
        .i_din  (w_acc_din),
        .o_dout (dout)
    );

    assign stall    = w_stall;
    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
//==============================================================================
// tb_cpu_mem_responder : four latencies driven in lockstep against a model.
// Revision 1.0
//==============================================================================
module tb_cpu_mem_responder;

    localparam int N = 4;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] din;
    logic        re;
    logic [3:0]  we;

    logic [31:0] dout_a [N];
    logic [31:0] rdc_a  [N];
    logic [31:0] wrc_a  [N];
    logic        stall_a[N];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            cpu_mem_responder #(
                .ADDR_BITS (12),
                .LATENCY   (lat_of(g))
            ) u_dut (
                .clk      (clk),
                .reset    (reset),
                .addr     (addr),
                .re       (re),
                .we       (we),
                .din      (din),
                .dout     (dout_a[g]),
                .stall    (stall_a[g]),
                .rd_count (rdc_a[g]),
                .wr_count (wrc_a[g])
            );
        end
    endgenerate

    // Behavioural model: per latency, a small word memory plus the cycle at
    // which each pending access lands and the first cycle it is free again.
    logic [31:0] m_mem   [N][8];
    bit          m_known [N][8];
    logic [31:0] m_dout  [N];
    bit          m_dknown[N];
    logic [31:0] m_rd    [N];
    logic [31:0] m_wr    [N];
    int          m_free  [N];
    bit          m_pend  [N];
    int          m_exec  [N];
    logic [31:0] p_addr  [N];
    logic [31:0] p_din   [N];
    logic [3:0]  p_we    [N];
    bit          p_re    [N];

    int cyc;
    int n_cmp;
    int n_bad;
    bit checking;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic execute(input int k, input logic [31:0] a, input bit r,
                           input logic [3:0] w, input logic [31:0] d);
        int i;
        i = int'(a[2:0]);
        if (r) begin
            m_dout[k]   = m_mem[k][i];
            m_dknown[k] = m_known[k][i];
            m_rd[k]     = m_rd[k] + 32'd1;
        end
        if (w != 4'b0000) begin
            for (int b = 0; b < 4; b++) begin
                if (w[b]) m_mem[k][i][8*b +: 8] = d[8*b +: 8];
            end
            if (w == 4'hF) m_known[k][i] = 1'b1;
            m_wr[k] = m_wr[k] + 32'd1;
        end
    endtask

    task automatic tick(input bit rs, input bit r, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = rs; re = r; we = w; addr = a; din = d;
        #1;
        for (int k = 0; k < N; k++) begin
            int L;
            bit req;
            bit idle;
            bit sexp;
            L    = lat_of(k);
            req  = r || (w != 4'b0000);
            idle = (cyc >= m_free[k]);
            sexp = rs ? 1'b0 : (!idle || (req && L > 0));
            if (checking) begin
                chk($sformatf("stall[L=%0d]", L), {31'b0, stall_a[k]}, {31'b0, sexp});
                if (m_dknown[k]) chk($sformatf("dout[L=%0d]", L), dout_a[k], m_dout[k]);
                chk($sformatf("rd_count[L=%0d]", L), rdc_a[k], m_rd[k]);
                chk($sformatf("wr_count[L=%0d]", L), wrc_a[k], m_wr[k]);
            end
            if (rs) begin
                m_pend[k]   = 1'b0;
                m_free[k]   = cyc + 1;
                m_dout[k]   = 32'd0;
                m_dknown[k] = 1'b1;
                m_rd[k]     = 32'd0;
                m_wr[k]     = 32'd0;
            end else begin
                if (idle && req) begin
                    m_pend[k] = 1'b1;
                    p_addr[k] = a; p_din[k] = d; p_we[k] = w; p_re[k] = r;
                    m_exec[k] = cyc + ((L > 0) ? L - 1 : 0);
                    m_free[k] = cyc + L;
                end
                if (m_pend[k] && m_exec[k] == cyc) begin
                    execute(k, p_addr[k], p_re[k], p_we[k], p_din[k]);
                    m_pend[k] = 1'b0;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle1();
        tick(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    endtask

    // One request followed by two quiet cycles: long enough for every latency.
    task automatic txn(input bit r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        tick(1'b0, r, w, a, d);
        idle1();
        idle1();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; checking = 1'b0;
        reset = 1'b1; re = 1'b0; we = 4'h0; addr = '0; din = '0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[k][i] = '0; m_known[k][i] = 1'b0;
            end
            m_dout[k] = '0; m_dknown[k] = 1'b0; m_rd[k] = '0; m_wr[k] = '0;
            m_free[k] = 0; m_pend[k] = 1'b0; m_exec[k] = 0;
            p_addr[k] = '0; p_din[k] = '0; p_we[k] = '0; p_re[k] = 1'b0;
        end

        tick(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        checking = 1'b1;
        tick(1'b1, 1'b1, 4'hF, 32'd3, 32'd1);
        chk("reset stall", {31'b0, stall_a[0]}, 32'd0);
        idle1();
        chk("reset dout", dout_a[0], 32'd0);
        chk("reset rd_count", rdc_a[0], 32'd0);
        chk("reset wr_count", wrc_a[0], 32'd0);

        tick(1'b0, 1'b0, 4'hF, 32'd5, 32'hDEADBEEF);
        chk("wr stall T", {31'b0, stall_a[0]}, 32'd1);
        idle1();
        chk("wr stall T+1", {31'b0, stall_a[0]}, 32'd1);
        idle1();
        chk("wr stall T+2", {31'b0, stall_a[0]}, 32'd0);
        chk("wr count 1", wrc_a[0], 32'd1);

        txn(1'b1, 4'h0, 32'd5, 32'd0);
        chk("rd DEADBEEF", dout_a[0], 32'hDEADBEEF);
        chk("rd count 1", rdc_a[0], 32'd1);

        txn(1'b0, 4'b0100, 32'd5, 32'h00AA0000);
        txn(1'b1, 4'h0, 32'd5, 32'd0);
        chk("masked write", dout_a[0], 32'hDEAABEEF);

        txn(1'b1, 4'hF, 32'd5, 32'd0);
        chk("read-first old", dout_a[0], 32'hDEAABEEF);
        chk("rmw rd_count", rdc_a[0], 32'd3);
        chk("rmw wr_count", wrc_a[0], 32'd3);
        txn(1'b1, 4'h0, 32'd5, 32'd0);
        chk("read after rmw", dout_a[0], 32'd0);

        txn(1'b0, 4'hF, 32'd7, 32'h12345678);
        tick(1'b0, 1'b0, 4'hF, 32'd7, 32'hFFFFFFFF);
        tick(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        chk("stall in reset", {31'b0, stall_a[0]}, 32'd0);
        idle1();
        chk("stall after abort", {31'b0, stall_a[0]}, 32'd0);
        chk("abort rd_count", rdc_a[0], 32'd0);
        chk("abort wr_count", wrc_a[0], 32'd0);
        txn(1'b1, 4'h0, 32'd7, 32'd0);
        chk("addr7 unchanged", dout_a[0], 32'h12345678);

        txn(1'b0, 4'hF, 32'd5, 32'hCAFEF00D);
        tick(1'b0, 1'b1, 4'h0, 32'd4096 + 32'd5, 32'd0);
        chk("L0 stall a", {31'b0, stall_a[1]}, 32'd0);
        tick(1'b0, 1'b1, 4'h0, 32'd5, 32'd0);
        chk("L0 stall b", {31'b0, stall_a[1]}, 32'd0);
        chk("L0 alias dout", dout_a[1], 32'hCAFEF00D);
        idle1();
        chk("L0 stall c", {31'b0, stall_a[1]}, 32'd0);
        chk("L0 direct dout", dout_a[1], 32'hCAFEF00D);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = $urandom;
            for (int h = 0; h < 4; h++) tick(1'b0, 1'b0, 4'hF, i, v);
        end

        for (int n = 0; n < 1500; n++) begin
            bit          rs;
            bit          r;
            logic [3:0]  w;
            logic [31:0] a;
            rs = ($urandom_range(96, 0) == 0);
            r  = $urandom_range(1, 0) == 1;
            if ($urandom_range(2, 0) == 0)      w = 4'h0;
            else if ($urandom_range(1, 0) == 1) w = 4'hF;
            else                                w = 4'($urandom);
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(7, 0));
            tick(rs, r, w, a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
